data_mem_scan: RTL and testbench
================================

Name: data_mem_scan

Overview:
- Parametrised successor to the single-cycle data memory used by the MIPS pipeline/multi-cycle benches.
- Word-addressed RAM with a CPU load/store port that has configurable wait states and a ready handshake.
- Adds a background scan engine that finds the signed minimum and its index over a programmable window, generalising the fixed MinVal/MinIndice outputs.
- Sits between the CPU data port and the testbench; synthesisable.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 256, number of words (power of two).
- ADDR_W, 32, CPU byte-address width.
- LATENCY, 2, wait states before ready (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- adr  in  ADDR_W  CPU byte address; word index = adr[log2(DEPTH)+1:2].
- write_data  in  WIDTH  store data.
- mem_read  in  1  load request, held until ready.
- mem_write  in  1  store request, held until ready.
- read_data  out  WIDTH  registered load data, valid while ready=1.
- ready  out  1  one-cycle completion pulse for the current access.
- scan_start  in  1  one-cycle pulse that starts a scan.
- scan_base  in  log2(DEPTH)  first word index of the scan window.
- scan_count  in  log2(DEPTH)+1  number of words to scan (0..DEPTH).
- scan_busy  out  1  high while a scan is in progress.
- scan_done  out  1  one-cycle pulse when a scan finishes.
- min_val  out  WIDTH  signed minimum found by the last completed scan.
- min_idx  out  log2(DEPTH)  word index of min_val.
- min_valid  out  1  high when min_val/min_idx hold a real result.

Behaviour:
- Reset (async, active-high):
  - CPU FSM goes to IDLE; scan FSM goes to S_IDLE.
  - read_data, ready, scan_busy, scan_done, min_val, min_idx and min_valid all clear to 0.
  - RAM contents are not cleared.
  - Reset asserted mid-access or mid-scan aborts the operation; no RAM write occurs in that cycle.
- CPU FSM (IDLE -> WAIT -> RESP -> IDLE):
  - IDLE: sample a request when mem_read|mem_write is high. Go to WAIT, loading a counter with LATENCY; if LATENCY=0, go directly to RESP.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP: ready=1 for exactly one cycle.
    - Load: read_data = RAM[word] sampled in this cycle.
    - Store: RAM[word] <= write_data at the end of this cycle.
  - RESP always returns to IDLE, so accesses have a minimum 1 idle cycle between them.
  - Total latency: ready is high LATENCY+1 cycles after the request is sampled.
  - read_data holds its value until the next load completes.
  - mem_read and mem_write both high: treated as a store; read_data is unchanged.
  - Out-of-range upper address bits are ignored (the address wraps modulo DEPTH).
- Scan FSM (S_IDLE -> S_RUN -> S_DONE -> S_IDLE):
  - scan_start in S_IDLE latches base, count and ptr=base.
    - count=0: go straight to S_DONE with min_valid=0 and min_val/min_idx=0.
  - scan_start while busy is ignored.
  - S_RUN: reads one word per cycle at ptr. The pointer wraps modulo DEPTH.
    - The first word initialises the running minimum.
    - Each later word is a signed compare; it replaces the minimum only if strictly less, so ties keep the earliest-scanned index.
  - Single RAM port arbitration: in any cycle where the CPU FSM is in RESP, the scan stalls with no ptr advance. CPU has priority.
  - After count words: go to S_DONE. scan_done=1 for one cycle; min_val/min_idx update in that cycle; min_valid=1.
  - scan_busy is high in S_RUN and S_DONE.
  - Results hold until the next scan completes or reset.
  - A store to a word that has already been scanned is not reflected in the current result. A store to a word not yet scanned is seen.
  - Scan latency with no CPU traffic: scan_done occurs count+1 cycles after scan_start.

Decomposition:
- Shared package/header holds:
  - CPU FSM state encodings: IDLE, WAIT, RESP.
  - Scan FSM state encodings: S_IDLE, S_RUN, S_DONE.
  - The log2 helper for index widths.
- One natural sub-module: min_scan_unit. It contains the scan FSM, pointer, count and running signed comparator. It drives the RAM read index through a mux and takes a stall input from the CPU FSM.
- The RAM array and CPU FSM stay in the top level.

Test Plan:
- Reset during WAIT of a store (LATENCY=2) -> no ready pulse; a following load of that address returns the old value; all outputs are 0 after reset.
- Store 32'h0000_00AB to adr 0x10, then load adr 0x10 with LATENCY=2 -> ready 3 cycles after each request; read_data=32'h0000_00AB.
- Preload words 0..7 = {5, -3, 7, -3, 9, 0, 1, 2}; scan base=0, count=8 -> scan_done 9 cycles after start; min_val=-3; min_idx=1 (tie keeps earliest); min_valid=1.
- DEPTH=256; words 254=10, 255=4, 0=6, 1=-1; scan base=254, count=4 -> wrap works; min_val=-1; min_idx=1.
- Scan with count=0 -> scan_done the next cycle; min_valid=0; min_val=0. A second scan_start while busy is ignored, so no extra scan_done pulse.
- Scan of 8 words with a CPU store of -100 to word 6 issued mid-scan, before ptr reaches 6 -> scan stalls during RESP; result min_val=-100, min_idx=6; scan_done is delayed by 1 cycle.

Source files
------------

// File: rtl/data_mem_scan_pkg.sv
// Shared types for the data memory with background min-scan: FSM encodings
// and the index-width helper.
package data_mem_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } cpu_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } scan_state_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_scan_min_scan_unit.sv
// Background scan engine: walks a wrapping window of RAM words one per cycle
// and reports the signed minimum and the index where it was first seen.
module min_scan_unit
    import data_mem_scan_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int IDX_W = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] base,
    input  logic [IDX_W:0]   count,
    input  logic             stall,
    input  logic [WIDTH-1:0] rd_data,
    output logic [IDX_W-1:0] rd_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_val,
    output logic [IDX_W-1:0] min_idx,
    output logic             min_valid
);

    scan_state_t state, next_state;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   left;
    logic             have_min;
    logic [WIDTH-1:0] run_min;
    logic [IDX_W-1:0] run_idx;

    logic             take;
    logic [WIDTH-1:0] best_val;
    logic [IDX_W-1:0] best_idx;
    logic             last_word;

    assign rd_idx    = ptr;
    assign last_word = (left == (IDX_W+1)'(1));

    // Strictly-less replacement keeps the earliest-scanned index on ties
    always_comb begin
        take     = !have_min || ($signed(rd_data) < $signed(run_min));
        best_val = take ? rd_data : run_min;
        best_idx = take ? ptr : run_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!stall && last_word) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Published results change only on the edge that enters S_DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            left      <= '0;
            have_min  <= 1'b0;
            run_min   <= '0;
            run_idx   <= '0;
            min_val   <= '0;
            min_idx   <= '0;
            min_valid <= 1'b0;
        end else if (state == S_IDLE && start) begin
            ptr      <= base;
            left     <= count;
            have_min <= 1'b0;
            if (count == '0) begin
                min_val   <= '0;
                min_idx   <= '0;
                min_valid <= 1'b0;
            end
        end else if (state == S_RUN && !stall) begin
            run_min  <= best_val;
            run_idx  <= best_idx;
            have_min <= 1'b1;
            ptr      <= ptr + IDX_W'(1);
            left     <= left - (IDX_W+1)'(1);
            if (last_word) begin
                min_val   <= best_val;
                min_idx   <= best_idx;
                min_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_scan.sv
// Word-addressed data memory with a wait-state CPU port and a background
// signed-minimum scan that yields the RAM port whenever the CPU responds.
module data_mem_scan
    import data_mem_scan_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          adr,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    output logic [WIDTH-1:0]           read_data,
    output logic                       ready,
    input  logic                       scan_start,
    input  logic [log2(DEPTH)-1:0]     scan_base,
    input  logic [log2(DEPTH):0]       scan_count,
    output logic                       scan_busy,
    output logic                       scan_done,
    output logic [WIDTH-1:0]           min_val,
    output logic [log2(DEPTH)-1:0]     min_idx,
    output logic                       min_valid
);

    localparam int IDX_W = log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    cpu_state_t cpu_state, cpu_next;

    logic [3:0]       wait_cnt;
    logic             is_store;
    logic [IDX_W-1:0] cpu_word;
    logic [WIDTH-1:0] store_data;

    logic             req;
    logic [IDX_W-1:0] req_word;
    logic [IDX_W-1:0] load_word;
    logic             load_is_store;

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] ram_idx;
    logic [WIDTH-1:0] ram_rd;
    logic             cpu_owns_ram;

    logic             unused_adr;

    assign req        = mem_read | mem_write;
    assign req_word   = adr[IDX_W+1:2];
    assign unused_adr = ^{adr[ADDR_W-1:IDX_W+2], adr[1:0]};

    assign ready         = (cpu_state == RESP);
    assign cpu_owns_ram  = (cpu_state == RESP);
    assign ram_idx       = cpu_owns_ram ? cpu_word : scan_idx;
    assign ram_rd        = mem[ram_idx];

    // With zero wait states RESP is entered straight from IDLE, before the
    // request fields have been latched
    assign load_word     = (cpu_state == IDLE) ? req_word  : cpu_word;
    assign load_is_store = (cpu_state == IDLE) ? mem_write : is_store;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_state <= IDLE;
        end else begin
            cpu_state <= cpu_next;
        end
    end

    always_comb begin
        cpu_next = cpu_state;
        unique case (cpu_state)
            IDLE: begin
                if (req) begin
                    cpu_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    cpu_next = RESP;
                end
            end
            RESP:    cpu_next = IDLE;
            default: cpu_next = IDLE;
        endcase
    end

    // Load data is captured on entry to RESP so it is valid alongside ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            is_store   <= 1'b0;
            cpu_word   <= '0;
            store_data <= '0;
            read_data  <= '0;
        end else begin
            if (cpu_state == IDLE && req) begin
                wait_cnt   <= 4'(LATENCY);
                is_store   <= mem_write;
                cpu_word   <= req_word;
                store_data <= write_data;
            end else if (cpu_state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (cpu_next == RESP && !load_is_store) begin
                read_data <= mem[load_word];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && cpu_state == RESP && is_store) begin
            mem[cpu_word] <= store_data;
        end
    end

    min_scan_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .start     (scan_start),
        .base      (scan_base),
        .count     (scan_count),
        .stall     (cpu_owns_ram),
        .rd_data   (ram_rd),
        .rd_idx    (scan_idx),
        .busy      (scan_busy),
        .done      (scan_done),
        .min_val   (min_val),
        .min_idx   (min_idx),
        .min_valid (min_valid)
    );

endmodule

// File: tb/tb_data_mem_scan.sv
// Self-checking bench for data_mem_scan: cycle-level reference model of the
// CPU port and scan engine, directed scenarios plus randomized traffic.
module tb_data_mem_scan;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 32;
    localparam int LATENCY = 2;
    localparam int IDX_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] adr = '0;
    logic [WIDTH-1:0]  write_data = '0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [WIDTH-1:0]  read_data;
    logic              ready;
    logic              scan_start = 1'b0;
    logic [IDX_W-1:0]  scan_base = '0;
    logic [IDX_W:0]    scan_count = '0;
    logic              scan_busy;
    logic              scan_done;
    logic [WIDTH-1:0]  min_val;
    logic [IDX_W-1:0]  min_idx;
    logic              min_valid;

    always #5 clk = ~clk;

    data_mem_scan #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adr        (adr),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .ready      (ready),
        .scan_start (scan_start),
        .scan_base  (scan_base),
        .scan_count (scan_count),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .min_val    (min_val),
        .min_idx    (min_idx),
        .min_valid  (min_valid)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    bit chk_en       = 1'b0;

    // Reference model state
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_busy, m_is_wr;
    int               m_wait;
    logic [IDX_W-1:0] m_word;
    logic [WIDTH-1:0] m_wdata;
    bit               s_run, s_have;
    int               s_left;
    logic [IDX_W-1:0] s_ptr, s_idx;
    logic [WIDTH-1:0] s_min;

    logic             exp_ready, exp_busy, exp_done, exp_valid;
    logic [WIDTH-1:0] exp_rdata, exp_min_val;
    logic [IDX_W-1:0] exp_min_idx;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model advances on each rising edge: CPU access timing, shadow RAM, scan progress
    always @(posedge clk) begin
        bit               was_resp;
        logic [WIDTH-1:0] v;
        was_resp = exp_ready;
        cyc++;
        if (rst) begin
            m_busy = 0; m_is_wr = 0; m_wait = 0; m_word = '0; m_wdata = '0;
            s_run = 0; s_have = 0; s_left = 0; s_ptr = '0; s_idx = '0; s_min = '0;
            exp_ready = 0; exp_busy = 0; exp_done = 0; exp_valid = 0;
            exp_rdata = '0; exp_min_val = '0; exp_min_idx = '0;
        end else begin
            if (was_resp) begin
                if (m_is_wr) m_mem[m_word] = m_wdata;
                m_busy = 0;
            end else if (!m_busy && (mem_read || mem_write)) begin
                m_busy  = 1;
                m_is_wr = mem_write;
                m_word  = adr[IDX_W+1:2];
                m_wdata = write_data;
                m_wait  = LATENCY;
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
            end
            exp_ready = m_busy && (m_wait == 0);
            if (exp_ready && !m_is_wr) exp_rdata = m_mem[m_word];

            if (exp_done) begin
                exp_done = 0;
                exp_busy = 0;
            end else if (!s_run && !exp_busy && scan_start) begin
                exp_busy = 1;
                if (scan_count == 0) begin
                    exp_done = 1; exp_valid = 0; exp_min_val = '0; exp_min_idx = '0;
                end else begin
                    s_run = 1; s_have = 0; s_left = int'(scan_count); s_ptr = scan_base;
                end
            end else if (s_run && !was_resp) begin
                v = m_mem[s_ptr];
                if (!s_have || $signed(v) < $signed(s_min)) begin
                    s_min = v;
                    s_idx = s_ptr;
                end
                s_have = 1;
                s_ptr  = s_ptr + 1'b1;
                s_left--;
                if (s_left == 0) begin
                    s_run = 0; exp_done = 1; exp_valid = 1;
                    exp_min_val = s_min; exp_min_idx = s_idx;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checkOutput("ready", ready, exp_ready);
            checkOutput("read_data", read_data, exp_rdata);
            checkOutput("scan_busy", scan_busy, exp_busy);
            checkOutput("scan_done", scan_done, exp_done);
            checkOutput("min_val", min_val, exp_min_val);
            checkOutput("min_idx", min_idx, exp_min_idx);
            checkOutput("min_valid", min_valid, exp_valid);
        end
    end

    task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                                 input logic [WIDTH-1:0] d, output int lat);
        int start_c;
        @(negedge clk);
        mem_read = rd; mem_write = wr; adr = a; write_data = d;
        @(posedge clk); #1;
        start_c = cyc;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            if (ready) begin
                lat = cyc - start_c + 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) checkOutput("ready_timeout", 0, 1);
        @(negedge clk);
        mem_read = 0; mem_write = 0;
    endtask

    task automatic startScan(input logic [IDX_W-1:0] b, input logic [IDX_W:0] c,
                             input bit extra, output int lat);
        int s_c;
        @(negedge clk);
        scan_start = 1; scan_base = b; scan_count = c;
        @(posedge clk); #1;
        s_c = cyc;
        lat = scan_done ? 1 : -1;
        @(negedge clk);
        scan_start = extra;
        scan_base  = b + 8'd17;
        scan_count = 9'd3;
        @(posedge clk); #1;
        if (lat < 0 && scan_done) lat = cyc - s_c + 1;
        @(negedge clk);
        scan_start = 0;
        for (int i = 0; i < 800 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (scan_done) lat = cyc - s_c + 1;
        end
        if (lat < 0) checkOutput("scan_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic cpuTraffic(input int n);
        int lat;
        int r;
        logic [WIDTH-1:0] d;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 9));
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'(int'($urandom_range(0, 8)) - 4);
            applyStimulus(r < 5 || r == 9, r >= 5, $urandom, d, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic scanTraffic(input int n);
        int lat;
        int r;
        logic [IDX_W:0] c;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      c = '0;
            else if (r == 1) c = 9'd256;
            else             c = 9'($urandom_range(1, 40));
            startScan(8'($urandom), c, $urandom_range(0, 1) == 1, lat);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    initial begin
        int lat, lat_c, dones;
        int pre [8] = '{5, -3, 7, -3, 9, 0, 1, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        @(posedge clk); #1;
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_busy", scan_busy, 0);
        checkOutput("rst_min_valid", min_valid, 0);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, ADDR_W'(i * 4), $urandom, lat);
        end

        applyStimulus(0, 1, 32'h10, 32'h0000_00AB, lat);
        checkOutput("store_latency", lat, 3);
        applyStimulus(1, 0, 32'h10, '0, lat);
        checkOutput("load_latency", lat, 3);
        checkOutput("load_data", read_data, 32'h0000_00AB);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, ADDR_W'(i * 4), 32'(pre[i]), lat);
        end
        startScan(8'd0, 9'd8, 0, lat);
        checkOutput("scan8_latency", lat, 9);
        checkOutput("scan8_min_val", min_val, 32'hFFFF_FFFD);
        checkOutput("scan8_min_idx", min_idx, 1);
        checkOutput("scan8_valid", min_valid, 1);

        fork
            startScan(8'd0, 9'd8, 0, lat);
            begin
                repeat (2) @(negedge clk);
                applyStimulus(0, 1, 32'h18, 32'hFFFF_FF9C, lat_c);
            end
        join
        checkOutput("stall_latency", lat, 10);
        checkOutput("stall_min_val", min_val, 32'hFFFF_FF9C);
        checkOutput("stall_min_idx", min_idx, 6);

        applyStimulus(0, 1, 32'h3F8, 32'd10, lat);
        applyStimulus(0, 1, 32'h3FC, 32'd4, lat);
        applyStimulus(0, 1, 32'h000, 32'd6, lat);
        applyStimulus(0, 1, 32'h004, 32'hFFFF_FFFF, lat);
        startScan(8'd254, 9'd4, 0, lat);
        checkOutput("wrap_latency", lat, 5);
        checkOutput("wrap_min_val", min_val, 32'hFFFF_FFFF);
        checkOutput("wrap_min_idx", min_idx, 1);

        applyStimulus(0, 1, 32'h40, 32'h1111_1111, lat);
        applyStimulus(1, 0, 32'h40, '0, lat);
        @(negedge clk);
        mem_write = 1; adr = 32'h40; write_data = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        rst = 1; mem_write = 0;
        @(posedge clk); #1;
        checkOutput("abort_ready", ready, 0);
        checkOutput("abort_read_data", read_data, 0);
        checkOutput("abort_min_val", min_val, 0);
        checkOutput("abort_min_idx", min_idx, 0);
        checkOutput("abort_min_valid", min_valid, 0);
        @(negedge clk);
        rst = 0;
        applyStimulus(1, 0, 32'h40, '0, lat);
        checkOutput("abort_old_value", read_data, 32'h1111_1111);

        startScan(8'd5, 9'd0, 1, lat);
        checkOutput("empty_latency", lat, 1);
        checkOutput("empty_valid", min_valid, 0);
        checkOutput("empty_min_val", min_val, 0);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (scan_done) dones++;
        end
        checkOutput("ignored_start_dones", dones, 0);

        fork
            cpuTraffic(60);
            scanTraffic(15);
        join

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
